mac_dot4_accum_seq: RTL and testbench

Sequencer and accumulator around a 4-lane signed 8-bit dot-product MAC pipeline. Accepts a stream of beats, each carrying four operand pairs and a last flag. Sums each beat's dot product into a 32-bit accumulator and emits one result per group, terminated by `in_last`. The block sits between the operand-fetch stage and the output writer in the PE. It hides the fixed, non-stallable MAC latency behind credit-based backpressure.

---
 rtl/mac_pkg.sv | 37 +++
 rtl/mac_dot4_pipe.sv | 70 +++++++
 rtl/mac_dot4_accum_seq.sv | 182 ++++++++++++++++++
 tb/tb_mac_dot4_accum_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and helpers for the dot4 MAC sequencer: lane/width constants,
// accumulator FSM states and a saturating 32-bit add.
package mac_pkg;

    localparam int MAC_LANES = 4;
    localparam int MAC_IN_W  = 8;
    localparam int MAC_SUM_W = 18;
    localparam int MAC_ACC_W = 32;

    typedef enum logic {
        ACC_EMPTY,
        ACC_PARTIAL
    } acc_state_t;

    typedef struct packed {
        logic [MAC_ACC_W-1:0] sum;
        logic                 ovf;
    } sat_add_t;

    // Two's-complement overflow only happens when both operands share a sign
    // and the wrapped result does not; clamp toward that sign.
    function automatic sat_add_t sat_add(input logic [MAC_ACC_W-1:0] a,
                                         input logic [MAC_ACC_W-1:0] b);
        sat_add_t             r;
        logic [MAC_ACC_W-1:0] s;
        s     = a + b;
        r.ovf = (a[MAC_ACC_W-1] == b[MAC_ACC_W-1]) && (s[MAC_ACC_W-1] != a[MAC_ACC_W-1]);
        if (r.ovf) begin
            r.sum = a[MAC_ACC_W-1] ? {1'b1, {(MAC_ACC_W-1){1'b0}}}
                                   : {1'b0, {(MAC_ACC_W-1){1'b1}}};
        end else begin
            r.sum = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_dot4_pipe.sv
// Fixed-latency, non-stallable 4-lane signed 8x8 dot product. Valid and last
// tags ride alongside the data through MAC_LATENCY register stages.
module mac_dot4_pipe
    import mac_pkg::*;
#(
    parameter int MAC_LATENCY = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              valid_i,
    input  logic                              last_i,
    input  logic [MAC_LANES*MAC_IN_W-1:0]     a_i,
    input  logic [MAC_LANES*MAC_IN_W-1:0]     b_i,
    output logic                              valid_o,
    output logic                              last_o,
    output logic signed [MAC_SUM_W-1:0]       sum_o
);

    logic signed [MAC_IN_W-1:0]    lane_a;
    logic signed [MAC_IN_W-1:0]    lane_b;
    logic signed [2*MAC_IN_W-1:0]  prod;
    logic signed [MAC_SUM_W-1:0]   dot;

    logic [MAC_LATENCY-1:0]        vld_q;
    logic [MAC_LATENCY-1:0]        lst_q;
    logic signed [MAC_SUM_W-1:0]   sum_q [MAC_LATENCY];

    always_comb begin
        dot    = '0;
        lane_a = '0;
        lane_b = '0;
        prod   = '0;
        for (int i = 0; i < MAC_LANES; i++) begin
            lane_a = a_i[i*MAC_IN_W +: MAC_IN_W];
            lane_b = b_i[i*MAC_IN_W +: MAC_IN_W];
            prod   = (2*MAC_IN_W)'(lane_a) * (2*MAC_IN_W)'(lane_b);
            dot    = dot + MAC_SUM_W'(prod);
        end
    end

    // NOTE: sequential state uses <= so every stage samples the pre-edge value
    // of its predecessor; blocking here would collapse the shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q[0] <= valid_i;
            lst_q[0] <= valid_i && last_i;
            for (int s = 1; s < MAC_LATENCY; s++) begin
                vld_q[s] <= vld_q[s-1];
                lst_q[s] <= lst_q[s-1];
            end
        end
    end

    // NOTE: data stages are deliberately not reset; they are only consumed
    // when the matching valid tag is set, and that tag is reset.
    always_ff @(posedge clk) begin
        sum_q[0] <= dot;
        for (int s = 1; s < MAC_LATENCY; s++) begin
            sum_q[s] <= sum_q[s-1];
        end
    end

    assign valid_o = vld_q[MAC_LATENCY-1];
    assign last_o  = lst_q[MAC_LATENCY-1];
    assign sum_o   = sum_q[MAC_LATENCY-1];

endmodule

// File: rtl/mac_dot4_accum_seq.sv
// Group accumulator, credit counter and show-ahead result FIFO around the dot4
// MAC pipe. Define MAC_ACC_SATURATE_EN for saturating adds with a sticky
// per-group overflow flag; otherwise sums wrap and out_overflow is 0.
module mac_dot4_accum_seq
    import mac_pkg::*;
#(
    parameter int MAC_LATENCY = 2,
    parameter int OUT_DEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAC_LANES*MAC_IN_W-1:0] in_dataa,
    input  logic [MAC_LANES*MAC_IN_W-1:0] in_datab,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAC_ACC_W-1:0]          out_result,
    output logic                          out_overflow
);

    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef MAC_ACC_SATURATE_EN
    localparam int FIFO_W = MAC_ACC_W + 1;
`else
    localparam int FIFO_W = MAC_ACC_W;
`endif

    logic                        ready_q;
    logic [CNT_W-1:0]            credits_q, credits_d;
    logic                        accept, last_accept, pop;

    logic                        pipe_valid, pipe_last;
    logic signed [MAC_SUM_W-1:0] pipe_sum;
    logic [MAC_ACC_W-1:0]        sum_ext, add_sum;

    acc_state_t                  state_q, state_d;
    logic [MAC_ACC_W-1:0]        acc_q, acc_d;
    logic                        fifo_wr;
    logic [MAC_ACC_W-1:0]        wr_result;
    logic [FIFO_W-1:0]           wr_data, rd_data;

    logic [FIFO_W-1:0]           mem_q [OUT_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]            count_q;
    logic                        fifo_full;

    assign accept      = in_valid && in_ready;
    assign last_accept = accept && in_last;
    assign pop         = out_valid && out_ready;
    // A same-cycle pop frees the slot the next last beat needs.
    assign in_ready    = ready_q && ((credits_q != '0) || pop);

    always_comb begin
        credits_d = credits_q;
        if (last_accept && !pop) begin
            credits_d = credits_q - CNT_W'(1);
        end else if (pop && !last_accept) begin
            credits_d = credits_q + CNT_W'(1);
        end
    end

    mac_dot4_pipe #(
        .MAC_LATENCY (MAC_LATENCY)
    ) u_pipe (
        .clk     (clock),
        .rst_n   (resetn),
        .valid_i (accept),
        .last_i  (in_last),
        .a_i     (in_dataa),
        .b_i     (in_datab),
        .valid_o (pipe_valid),
        .last_o  (pipe_last),
        .sum_o   (pipe_sum)
    );

    assign sum_ext = MAC_ACC_W'(pipe_sum);

`ifdef MAC_ACC_SATURATE_EN
    logic     ovf_q, ovf_d, wr_ovf, add_ovf;
    sat_add_t add_res;
    assign add_res = sat_add(acc_q, sum_ext);
    assign add_sum = add_res.sum;
    assign add_ovf = add_res.ovf;
    assign wr_data = {wr_ovf, wr_result};
`else
    assign add_sum = acc_q + sum_ext;
    assign wr_data = wr_result;
`endif

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        fifo_wr   = 1'b0;
        wr_result = '0;
`ifdef MAC_ACC_SATURATE_EN
        ovf_d     = ovf_q;
        wr_ovf    = 1'b0;
`endif
        if (pipe_valid) begin
            case (state_q)
                ACC_EMPTY: begin
                    if (pipe_last) begin
                        fifo_wr   = 1'b1;
                        wr_result = sum_ext;
                    end else begin
                        acc_d   = sum_ext;
                        state_d = ACC_PARTIAL;
                    end
                end
                ACC_PARTIAL: begin
                    if (pipe_last) begin
                        fifo_wr   = 1'b1;
                        wr_result = add_sum;
                        acc_d     = '0;
                        state_d   = ACC_EMPTY;
`ifdef MAC_ACC_SATURATE_EN
                        wr_ovf    = ovf_q || add_ovf;
                        ovf_d     = 1'b0;
`endif
                    end else begin
                        acc_d = add_sum;
`ifdef MAC_ACC_SATURATE_EN
                        ovf_d = ovf_q || add_ovf;
`endif
                    end
                end
                default: state_d = ACC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ready_q   <= 1'b0;
            credits_q <= CNT_W'(OUT_DEPTH);
            state_q   <= ACC_EMPTY;
            acc_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            ready_q   <= 1'b1;
            credits_q <= credits_d;
            state_q   <= state_d;
            acc_q     <= acc_d;
            if (fifo_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q   <= count_q + CNT_W'(fifo_wr) - CNT_W'(pop);
        end
    end

`ifdef MAC_ACC_SATURATE_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) ovf_q <= 1'b0;
        else         ovf_q <= ovf_d;
    end
`endif

    always_ff @(posedge clock) begin
        if (fifo_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign fifo_full  = (count_q == CNT_W'(OUT_DEPTH));
    assign out_valid  = (count_q != '0);
    assign rd_data    = mem_q[rd_ptr_q];
    assign out_result = out_valid ? rd_data[MAC_ACC_W-1:0] : '0;
`ifdef MAC_ACC_SATURATE_EN
    assign out_overflow = out_valid && rd_data[MAC_ACC_W];
`else
    assign out_overflow = 1'b0;
`endif

    // Credits reserve a FIFO slot per in-flight group, so this must never fire.
    a_no_fifo_overflow: assert property (@(posedge clock) disable iff (!resetn)
        !(fifo_wr && fifo_full));

endmodule

// File: tb/tb_mac_dot4_accum_seq.sv
// Directed, table-driven bench for mac_dot4_accum_seq (default parameters).
module tb_mac_dot4_accum_seq;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_dataa = '0;
    logic [31:0] in_datab = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    mac_dot4_accum_seq #(
        .MAC_LATENCY (LAT),
        .OUT_DEPTH   (DEPTH)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dataa     (in_dataa),
        .in_datab     (in_datab),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        last;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [31:0] lanes(input int l0, input int l1, input int l2, input int l3);
        return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    // Offers one beat and returns at the negedge after it was accepted; in_valid stays high.
    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
        int waited;
        in_dataa = a;
        in_datab = b;
        in_last  = last;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(negedge clock);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int w;
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clock);
            w++;
        end
        check({name, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic expect_result(input string name, input logic [31:0] exp_res, input logic exp_ovf);
        wait_valid(name);
        check({name, "_result"}, out_result, exp_res);
        check({name, "_ovf"}, 32'(out_overflow), 32'(exp_ovf));
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic run_long(input int n);
        longint      s;
        logic [31:0] e;
        logic        o;
        for (int i = 0; i < n; i++) begin
            send_beat(lanes(127, 127, 127, 127), lanes(127, 127, 127, 127), i == n - 1);
        end
        idle();
        s = longint'(n) * 64'sd64516;
`ifdef MAC_ACC_SATURATE_EN
        if (s > 64'sd2147483647) begin
            e = 32'h7FFF_FFFF;
            o = 1'b1;
        end else begin
            e = s[31:0];
            o = 1'b0;
        end
`else
        e = s[31:0];
        o = 1'b0;
`endif
        expect_result($sformatf("long%0d", n), e, o);
    endtask

    initial begin
        int acc_n;

        vecs[0] = '{lanes(1, 1, 1, 1),         lanes(2, 2, 2, 2),         1'b0, 32'd0};
        vecs[1] = '{lanes(1, 1, 1, 1),         lanes(2, 2, 2, 2),         1'b0, 32'd0};
        vecs[2] = '{lanes(1, 1, 1, 1),         lanes(2, 2, 2, 2),         1'b1, 32'd24};
        vecs[3] = '{lanes(-128, -128, -128, -128), lanes(-128, -128, -128, -128), 1'b1, 32'd65536};
        vecs[4] = '{lanes(127, 127, 127, 127), lanes(-128, -128, -128, -128), 1'b1, 32'(-65024)};
        vecs[5] = '{lanes(1, -2, 3, -4),       lanes(5, 6, -7, -8),       1'b1, 32'd4};
        vecs[6] = '{lanes(100, -50, 25, -128), lanes(-3, 7, 127, 1),      1'b1, 32'd2397};

        // Reset state
        @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_ovf", 32'(out_overflow), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Table vectors: one 3-beat group then four single-beat groups
        for (int i = 0; i < 7; i++) begin
            send_beat(vecs[i].a, vecs[i].b, vecs[i].last);
            if (vecs[i].last) begin
                idle();
                expect_result($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
            end
        end

        // Latency: out_valid rises LAT edges after the accepting edge
        send_beat(lanes(1, 1, 1, 1), lanes(1, 1, 1, 1), 1'b1);
        idle();
        for (int k = 0; k <= LAT; k++) begin
            check($sformatf("lat_k%0d", k), 32'(out_valid), 32'(k == LAT));
            if (k < LAT) @(negedge clock);
        end
        expect_result("lat", 32'd4, 1'b0);

        // Backpressure: exactly DEPTH single-beat groups accepted
        acc_n    = 0;
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_dataa = lanes(acc_n + 1, 0, 0, 0);
            in_datab = lanes(1, 0, 0, 0);
            if (in_ready) acc_n++;
            @(negedge clock);
        end
        check("bp_accepted", 32'(acc_n), 32'(DEPTH));
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_head_hold", out_result, 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp_ready_on_pop", 32'(in_ready), 32'd1);
        @(negedge clock);
        out_ready = 1'b0;
        idle();
        #1;
        check("bp_ready_after_pop", 32'(in_ready), 32'd0);
        for (int r = 2; r <= DEPTH + 1; r++) begin
            expect_result($sformatf("bp_r%0d", r), 32'(r), 1'b0);
        end

        // Back-to-back groups of length 1, 2, 1
        send_beat(lanes(10, 0, 0, 0), lanes(1, 0, 0, 0), 1'b1);
        send_beat(lanes(2, 2, 2, 2),  lanes(3, 3, 3, 3), 1'b0);
        send_beat(lanes(-1, 0, 0, 0), lanes(5, 0, 0, 0), 1'b1);
        send_beat(lanes(7, 0, 0, 0),  lanes(7, 0, 0, 0), 1'b1);
        idle();
        expect_result("b2b_g1", 32'd10, 1'b0);
        expect_result("b2b_g2", 32'd19, 1'b0);
        expect_result("b2b_g3", 32'd49, 1'b0);

        // Long groups: below and beyond the signed 32-bit range
        run_long(33000);
        run_long(34000);

        // Reset mid-group with one result held in the FIFO
        send_beat(lanes(5, 0, 0, 0), lanes(5, 0, 0, 0), 1'b1);
        idle();
        wait_valid("mid_pre");
        send_beat(lanes(3, 3, 3, 3), lanes(3, 3, 3, 3), 1'b0);
        send_beat(lanes(3, 3, 3, 3), lanes(3, 3, 3, 3), 1'b0);
        idle();
        resetn = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        check("mid_rst_in_ready2", 32'(in_ready), 32'd0);
        check("mid_rst_out_valid2", 32'(out_valid), 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        check("mid_post_in_ready", 32'(in_ready), 32'd1);
        check("mid_post_out_valid", 32'(out_valid), 32'd0);
        send_beat(lanes(1, 1, 1, 1), lanes(1, 1, 1, 1), 1'b1);
        idle();
        expect_result("mid_new", 32'd4, 1'b0);
        repeat (LAT + 3) @(negedge clock);
        check("mid_no_stale", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
